// File: rtl/bf16_pkg.sv
// Shared types and bf16 field helpers for the min/max reduction engine.
// NaN folding policy is selected by BF16_REDUCE_NAN_EN.
package bf16_pkg;

  typedef enum logic [1:0] {
    RED_IDLE,
    RED_ACCUM,
    RED_DONE
  } bf16_red_state_e;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

  localparam int BF16_EXP_MSB = 14;
  localparam int BF16_EXP_LSB = 7;
  localparam int BF16_MAN_MSB = 6;
  localparam int BF16_MAN_LSB = 0;

  function automatic logic is_nan(input logic [15:0] x);
    return (&x[BF16_EXP_MSB:BF16_EXP_LSB]) &&
           (|x[BF16_MAN_MSB:BF16_MAN_LSB]);
  endfunction

endpackage

// File: rtl/bf16_minmax_reduce_if.sv
// Element stream in, reduced result out.
// master = stream source/result sink, slave = reduction engine.
interface bf16_minmax_reduce_if #(
  parameter int CNT_W = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [15:0]      in_data_i;
  logic             in_last_i;
  logic             mode_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [15:0]      out_data_o;
  logic [CNT_W-1:0] out_count_o;
  logic             busy_o;

  modport master (
    output in_valid_i, in_data_i, in_last_i,
    output mode_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o,
    input  out_count_o, busy_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_last_i,
    input  mode_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o,
    output out_count_o, busy_o
  );
endinterface

// File: rtl/bf16_minmax_cmp.sv
// Combinational bf16 min/max under sign-magnitude total order.
// mode 0 selects the smaller operand, mode 1 the larger.
module bf16_minmax_cmp (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        mode,
  output logic [15:0] y
);

  logic [15:0] ka;
  logic [15:0] kb;
  logic        a_ge;

  // Map to an unsigned key: negatives flip below positives, -0 < +0.
  function automatic logic [15:0] key(input logic [15:0] x);
    return {~x[15], x[15] ? ~x[14:0] : x[14:0]};
  endfunction

  always_comb begin
    ka   = key(a);
    kb   = key(b);
    a_ge = (ka >= kb);
    y    = (mode == a_ge) ? a : b;
  end

endmodule

// File: rtl/bf16_minmax_reduce.sv
// Streaming bf16 min/max reduction: folds one element per cycle.
// Define BF16_REDUCE_NAN_EN to skip NaN elements during folding.
module bf16_minmax_reduce
  import bf16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  bf16_minmax_reduce_if.slave io
);

  bf16_red_state_e  state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      cmp_y;
  logic [15:0]      acc_new;
  logic             accept;
`ifdef BF16_REDUCE_NAN_EN
  logic             acc_ok_q, acc_ok_d;
  logic             ok_in;
`endif

  bf16_minmax_cmp u_cmp (
    .a    (acc_q),
    .b    (io.in_data_i),
    .mode (mode_q),
    .y    (cmp_y)
  );

  always_comb begin
    accept = io.in_valid_i & in_ready_q;
`ifdef BF16_REDUCE_NAN_EN
    ok_in    = (state_q == RED_ACCUM) & acc_ok_q;
    acc_ok_d = acc_ok_q;
    if (is_nan(io.in_data_i)) begin
      acc_new = ok_in ? acc_q : BF16_QNAN;
    end else begin
      acc_new = ok_in ? cmp_y : io.in_data_i;
    end
`else
    acc_new = (state_q == RED_IDLE) ? io.in_data_i : cmp_y;
`endif
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      RED_IDLE: begin
        if (accept) begin
          acc_d   = acc_new;
          mode_d  = io.mode_i;
          cnt_d   = CNT_W'(1);
          state_d = io.in_last_i ? RED_DONE : RED_ACCUM;
        end
      end
      RED_ACCUM: begin
        if (accept) begin
          acc_d = acc_new;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (io.in_last_i) state_d = RED_DONE;
        end
      end
      RED_DONE: begin
        if (io.out_ready_i) state_d = RED_IDLE;
      end
      default: state_d = RED_IDLE;
    endcase
`ifdef BF16_REDUCE_NAN_EN
    if (accept) acc_ok_d = ok_in | ~is_nan(io.in_data_i);
`endif
    in_ready_d  = (state_d != RED_DONE);
    out_valid_d = (state_d == RED_DONE);
    busy_d      = (state_d != RED_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RED_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef BF16_REDUCE_NAN_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_ok_q <= 1'b0;
    else         acc_ok_q <= acc_ok_d;
  end
`endif

  assign io.in_ready_o  = in_ready_q;
  assign io.out_valid_o = out_valid_q;
  assign io.busy_o      = busy_q;
  assign io.out_data_o  = acc_q;
  assign io.out_count_o = cnt_q;

endmodule

// File: tb/tb_bf16_minmax_reduce.sv
// Self-checking bench: two engines (CNT_W 8 and 2) share one stimulus.
// Vectors, hand sequences and random reductions against a value model.
module tb_bf16_minmax_reduce;

  logic clk = 1'b0;
  logic rst_n;
  logic v, l, m, ordy;
  logic [15:0] d;

  always #5 clk = ~clk;

  bf16_minmax_reduce_if #(.CNT_W(8)) if8 ();
  bf16_minmax_reduce_if #(.CNT_W(2)) if2 ();

  assign if8.in_valid_i  = v;
  assign if8.in_data_i   = d;
  assign if8.in_last_i   = l;
  assign if8.mode_i      = m;
  assign if8.out_ready_i = ordy;
  assign if2.in_valid_i  = v;
  assign if2.in_data_i   = d;
  assign if2.in_last_i   = l;
  assign if2.mode_i      = m;
  assign if2.out_ready_i = ordy;

  bf16_minmax_reduce #(.CNT_W(8)) u_dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (if8)
  );

  bf16_minmax_reduce #(.CNT_W(2)) u_dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (if2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    bit          mode;
    int          n;
    logic [15:0] e[8];
    logic [15:0] exp;
  } vec_t;

  vec_t tab[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Real-number-like order: negatives below zero, -0 just below +0.
  function automatic int ord(input logic [15:0] x);
    int mag;
    mag = int'(x[14:0]);
    return x[15] ? -mag - 1 : mag;
  endfunction

  function automatic bit m_nan(input logic [15:0] x);
    return ((int'(x) >> 7) % 256 == 255) && (int'(x) % 128 != 0);
  endfunction

  function automatic logic [15:0] ref_reduce(input bit mode,
                                             input logic [15:0] q[$]);
    logic [15:0] best;
    bit have;
    have = 0;
    best = 16'h0000;
    foreach (q[i]) begin
`ifdef BF16_REDUCE_NAN_EN
      if (m_nan(q[i])) continue;
`endif
      if (!have) best = q[i];
      else if (mode && ord(q[i]) > ord(best)) best = q[i];
      else if (!mode && ord(q[i]) < ord(best)) best = q[i];
      have = 1;
    end
    return have ? best : 16'h7FC0;
  endfunction

  task automatic chk_out(input string nm, input logic [15:0] ed,
                         input int n);
    chk({nm, "/data8"}, 32'(if8.out_data_o), 32'(ed));
    chk({nm, "/cnt8"}, 32'(if8.out_count_o), n > 255 ? 255 : n);
    chk({nm, "/data2"}, 32'(if2.out_data_o), 32'(ed));
    chk({nm, "/cnt2"}, 32'(if2.out_count_o), n > 3 ? 3 : n);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "/valid"}, 32'(if8.out_valid_o), 0);
    chk({nm, "/ready"}, 32'(if8.in_ready_o), 1);
    chk({nm, "/busy"}, 32'(if8.busy_o), 0);
    chk_out(nm, 16'h0000, 0);
    chk({nm, "/valid2"}, 32'(if2.out_valid_o), 0);
  endtask

  // Entered and left at posedge+1.
  task automatic run(input string nm, input bit mode,
                     input logic [15:0] q[$], input int gap,
                     input int hold, input logic [15:0] ed);
    foreach (q[i]) begin
      repeat ($urandom_range(0, gap)) begin
        v = 0;
        @(posedge clk); #1;
      end
      v = 1;
      d = q[i];
      l = (i == q.size() - 1);
      m = (i == 0) ? mode : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({nm, "/in_ready"}, 32'(if8.in_ready_o), 1);
      @(posedge clk); #1;
    end
    v = 0;
    l = 0;
    d = $urandom;
    @(negedge clk);
    chk({nm, "/lat8"}, 32'(if8.out_valid_o), 1);
    chk({nm, "/lat2"}, 32'(if2.out_valid_o), 1);
    chk_out(nm, ed, q.size());
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, "/hold_valid"}, 32'(if8.out_valid_o), 1);
      chk({nm, "/hold_rdy"}, 32'(if8.in_ready_o), 0);
      chk({nm, "/hold_busy"}, 32'(if8.busy_o), 1);
      chk_out({nm, "/hold"}, ed, q.size());
    end
    ordy = 1;
    v = 1;
    @(posedge clk); #1;
    ordy = 0;
    v = 0;
    @(negedge clk);
    chk({nm, "/post_valid"}, 32'(if8.out_valid_o), 0);
    chk({nm, "/post_rdy"}, 32'(if8.in_ready_o), 1);
    chk({nm, "/post_busy"}, 32'(if8.busy_o), 0);
    chk({nm, "/post_cnt"}, 32'(if8.out_count_o), q.size());
    @(posedge clk); #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] spec[8];

  initial begin
    tab[0] = '{"min3", 0, 3, '{16'h3F80, 16'h4000, 16'hBF80, 0, 0, 0, 0, 0},
               16'hBF80};
    tab[1] = '{"max_neg", 1, 2, '{16'hC000, 16'hBF80, 0, 0, 0, 0, 0, 0},
               16'hBF80};
    tab[2] = '{"max_z", 1, 2, '{16'h8000, 16'h0000, 0, 0, 0, 0, 0, 0},
               16'h0000};
    tab[3] = '{"min_z", 0, 2, '{16'h8000, 16'h0000, 0, 0, 0, 0, 0, 0},
               16'h8000};
    tab[4] = '{"single", 1, 1, '{16'h4000, 0, 0, 0, 0, 0, 0, 0},
               16'h4000};
    tab[5] = '{"max6", 1, 6, '{16'h3F80, 16'hC000, 16'h7F80, 16'h4000,
               16'hFF80, 16'h0000, 0, 0}, 16'h7F80};
    tab[6] = '{"min6", 0, 6, '{16'h3F80, 16'hC000, 16'h7F80, 16'h4000,
               16'hFF80, 16'h0000, 0, 0}, 16'hFF80};
    spec = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80,
             16'h7FC1, 16'hFFC1, 16'h3F80, 16'hBF80};

    rst_n = 0;
    v = 0; l = 0; m = 0; ordy = 0; d = 16'h1234;
    #12;
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) begin
      q.delete();
      for (int k = 0; k < tab[t].n; k++) q.push_back(tab[t].e[k]);
      run(tab[t].nm, tab[t].mode, q, 0, (t == 4) ? 5 : 0, tab[t].exp);
    end

    // Abort mid-reduction, then prove the old acc is gone.
    v = 1; l = 0; m = 1; d = 16'h7F00;
    @(posedge clk); #1;
    d = 16'h7E00;
    @(posedge clk); #1;
    v = 0;
    @(negedge clk);
    chk("mid/busy", 32'(if8.busy_o), 1);
    @(posedge clk); #1;
    rst_n = 0;
    #2;
    chk_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1;
    q = '{16'h3F80};
    run("after_rst", 1, q, 0, 0, 16'h3F80);

`ifdef BF16_REDUCE_NAN_EN
    q = '{16'h7FC1, 16'h3F80};
    run("nan_skip", 0, q, 0, 0, 16'h3F80);
    q = '{16'hFFC1, 16'h7F81};
    run("all_nan", 0, q, 0, 0, 16'h7FC0);
`else
    q = '{16'h7FC1, 16'h3F80};
    run("nan_ord", 1, q, 0, 0, 16'h7FC1);
    q = '{16'hFFC1, 16'hFF80};
    run("nnan_ord", 0, q, 0, 0, 16'hFFC1);
`endif

    for (int r = 0; r < 40; r++) begin
      bit md;
      int n;
      md = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 8);
      q.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) q.push_back(spec[$urandom_range(0, 7)]);
        else q.push_back(16'($urandom));
      end
      run($sformatf("rand%0d", r), md, q, 2, $urandom_range(0, 2),
          ref_reduce(md, q));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_minmax_reduce.md
# bf16_minmax_reduce

Streaming bfloat16 min/max reduction engine in the FPU: accepts a valid/ready stream of bf16 elements terminated by a `last` flag and folds them one per cycle through a sign-magnitude min/max comparator. It then presents the single reduced result and the element count on a valid/ready output port. It is the initiator side of the FPU min/max comparison interface: it sequences operands into the comparator (`rs1` = accumulator, `rs2` = new element, `mode`) and consumes `rd`. Used by vector/reduction instructions in front of writeback.

## Interface
- Parameter `CNT_W`, default 8: width of the element counter.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  input  1  clock
- `rst_ni`  input  1  asynchronous active-low reset
- `in_valid_i`  input  1  element valid
- `in_ready_o`  output  1  element accepted when `in_valid_i & in_ready_o`
- `in_data_i`  input  16  bf16 element
- `in_last_i`  input  1  final element of the reduction
- `mode_i`  input  1  0 = min, 1 = max; sampled only with the first element
- `out_valid_o`  output  1  result valid
- `out_ready_i`  input  1  result consumed when `out_valid_o & out_ready_i`
- `out_data_o`  output  16  reduced bf16 result
- `out_count_o`  output  CNT_W  number of elements accepted, saturating
- `busy_o`  output  1  high in ACCUM or DONE

## Operation
- FSM states are IDLE, ACCUM and DONE.
- **IDLE:** `in_ready_o`=1. On accept: acc←`in_data_i`, mode←`mode_i`, cnt←1. Go to DONE if `in_last_i`, else ACCUM.
- **ACCUM:** `in_ready_o`=1. On accept: acc←cmp(acc, `in_data_i`, mode), cnt←sat(cnt+1). Go to DONE if `in_last_i`. `mode_i` is ignored.
- **DONE:** `in_ready_o`=0, `out_valid_o`=1. On `out_ready_i`, go to IDLE.
- No element is accepted in the DONE cycle, including the handshake cycle.
- Ordering follows sign-magnitude total order:
  - positive beats negative.
  - Same sign: larger magnitude is greater if positive, smaller if negative.
  - -0 (0x8000) < +0 (0x0000).
  - Equal ordering implies identical bits, so ties are irrelevant.
- Infinities order naturally. NaN handling is set by the macro below.
- Counter: cnt saturates at 2^CNT_W−1 and never wraps. The reduction continues correctly past saturation.
- `out_data_o`/`out_count_o` are driven from the acc/cnt registers. They are stable while `out_valid_o & !out_ready_i`.
- Idle gaps (`in_valid_i`=0) in IDLE/ACCUM hold state indefinitely.
- Reset (any state, including mid-reduction): state IDLE, acc=0x0000, cnt=0, mode=0.
  - Output values at reset: `out_valid_o`=0, `in_ready_o`=1, `busy_o`=0, `out_data_o`=0x0000, `out_count_o`=0.

## Timing
- Throughput is 1 element/cycle in IDLE/ACCUM.
- Latency: `out_valid_o` rises the cycle after the last element is accepted.
- There is at least 1 dead cycle between reductions: the DONE handshake cycle, then IDLE.
- `in_ready_o` depends only on state. It has no combinational path from any input.
- The comparator is combinational between the acc register and `in_data_i`. There is no inner pipeline.

## Configuration
- Macro: `BF16_REDUCE_NAN_EN`. Defined:
  - NaN inputs (exp=0xFF, mantissa≠0) are not folded. They are still counted.
  - An internal `acc_ok` bit tracks whether any non-NaN element has been folded. The first non-NaN element loads acc directly.
  - If all elements were NaN, the result is the canonical qNaN 0x7FC0.
- Undefined:
  - NaNs are ordered purely by bit pattern under the sign-magnitude rule. +NaN beats +Inf; −NaN loses to −Inf.
  - No `acc_ok` logic is present.

## Structure
- Shared package `bf16_pkg`:
  - FSM state enum `bf16_red_state_e`.
  - `BF16_QNAN` = 16'h7FC0.
  - Field constants `BF16_EXP_MSB/LSB` and `BF16_MAN_MSB/LSB`.
  - `is_nan` function.
- Sub-module `bf16_minmax_cmp`: combinational. Inputs are a, b (16) and mode; output is y (16). Implements the ordering above.
- Top level holds the FSM, acc/cnt/mode registers and NaN gating.

## Test plan
- Min over {0x3F80, 0x4000, 0xBF80(last)} back-to-back → `out_data_o`=0xBF80, count=3, valid 1 cycle after last.
- Max over {0xC000, 0xBF80(last)} → 0xBF80. Max over {0x8000, 0x0000} → 0x0000. Min over the same pair → 0x8000.
- Single element 0x4000 with last, mode=max → 0x4000, count=1. Hold `out_ready_i`=0 for 5 cycles: data stable, `in_ready_o`=0. Handshake → IDLE, `in_ready_o`=1 next cycle.
- CNT_W=2, reduce 6 elements → count=3 (saturated), result still correct. Also `mode_i` toggled mid-stream is ignored.
- Drop `rst_ni` mid-ACCUM after 2 elements → all outputs at reset values. A new reduction afterward is unaffected by prior acc.
- With `BF16_REDUCE_NAN_EN`: min {0x7FC1, 0x3F80} → 0x3F80, count 2. All-NaN {0xFFC1, 0x7F81} → 0x7FC0. Without the macro: max {0x7FC1, 0x3F80} → 0x7FC1.
